// File: rtl/reg_file_16x16.sv
// 16 x 16-bit register file with two one-hot-addressed read ports and one write port.
// R0 always reads as zero and cannot be written.
// A wordline with more than one bit set suppresses the write and sets the sticky WLError flag.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to any read port that
// selects the same register.
module reg_file_16x16 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REGS-1:0]   SrcWL1,
    input  logic [NUM_REGS-1:0]   SrcWL2,
    input  logic [NUM_REGS-1:0]   DstWL,
    input  logic                  WriteReg,
    input  logic [DATA_WIDTH-1:0] DstData,
    output logic [DATA_WIDTH-1:0] SrcData1,
    output logic [DATA_WIDTH-1:0] SrcData2,
    output logic                  WLError
);

    // R0 has no storage; it is a constant zero.
    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
    logic                  r_wl_error;

    logic                  w_src1_bad;
    logic                  w_src2_bad;
    logic                  w_dst_bad;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_view [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_src_data1;
    logic [DATA_WIDTH-1:0] w_src_data2;

    // True when more than one bit of the wordline is set.
    function automatic logic is_multi_hot(input logic [NUM_REGS-1:0] wl);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (wl[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        return multi;
    endfunction

    // Wordline sanity checks and the qualified write enable.
    always_comb begin
        w_src1_bad = is_multi_hot(SrcWL1);
        w_src2_bad = is_multi_hot(SrcWL2);
        w_dst_bad  = is_multi_hot(DstWL);
        // A malformed destination wordline drops the whole write.
        w_wr_en    = WriteReg && !w_dst_bad;
    end

    // Per-register value as seen by the read ports (stored value, or forwarded write data).
    always_comb begin
        w_view[0] = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            w_view[i] = r_regs[i];
`ifdef REGFILE_BYPASS_EN
            // w_wr_en already excludes malformed writes; index 0 is never forwarded.
            if (w_wr_en && DstWL[i]) begin
                w_view[i] = DstData;
            end
`endif
        end
    end

    // Read ports: OR of every selected register, so a zero wordline reads zero.
    always_comb begin
        w_src_data1 = '0;
        w_src_data2 = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (SrcWL1[i]) begin
                w_src_data1 = w_src_data1 | w_view[i];
            end
            if (SrcWL2[i]) begin
                w_src_data2 = w_src_data2 | w_view[i];
            end
        end
    end

    // Register storage and sticky wordline-error flag, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
            r_wl_error <= 1'b0;
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (w_wr_en && DstWL[i]) begin
                    r_regs[i] <= DstData;
                end
            end
            if (w_src1_bad || w_src2_bad || (WriteReg && w_dst_bad)) begin
                r_wl_error <= 1'b1;
            end
        end
    end

    assign SrcData1 = w_src_data1;
    assign SrcData2 = w_src_data2;
    assign WLError  = r_wl_error;

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed self-checking bench for reg_file_16x16 (expectations follow REGFILE_BYPASS_EN).
module tb_reg_file_16x16;

    logic        clk;
    logic        rst_n;
    logic [15:0] SrcWL1;
    logic [15:0] SrcWL2;
    logic [15:0] DstWL;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;
    logic        WLError;

    int vectors;
    int miscompares;

    reg_file_16x16 #(
        .DATA_WIDTH(16),
        .NUM_REGS  (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SrcWL1  (SrcWL1),
        .SrcWL2  (SrcWL2),
        .DstWL   (DstWL),
        .WriteReg(WriteReg),
        .DstData (DstData),
        .SrcData1(SrcData1),
        .SrcData2(SrcData2),
        .WLError (WLError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write on the next edge, then return write inputs to idle.
    task automatic do_write(input logic [15:0] wl, input logic [15:0] data);
        @(negedge clk);
        WriteReg = 1'b1;
        DstWL    = wl;
        DstData  = data;
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        DstWL    = '0;
        DstData  = '0;
    endtask

    task automatic idle_cycle;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) idle_cycle();
        rst_n = 1'b1;
        do_write(16'h0020, 16'hBEEF);
        SrcWL1 = 16'h0020;
        #1;
        vectors++;
        if (SrcData1 !== 16'hBEEF) begin
            $display("FAIL reset_prewrite: got %h want %h", SrcData1, 16'hBEEF);
            miscompares++;
        end
        // Reset wins over a concurrent write.
        @(negedge clk);
        rst_n    = 1'b0;
        WriteReg = 1'b1;
        DstWL    = 16'h0020;
        DstData  = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n    = 1'b1;
        WriteReg = 1'b0;
        DstWL    = '0;
        DstData  = '0;
        #1;
        vectors++;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL reset_r5_cleared: got %h want %h", SrcData1, 16'h0000);
            miscompares++;
        end
        vectors++;
        if (WLError !== 1'b0) begin
            $display("FAIL reset_wlerror: got %b want %b", WLError, 1'b0);
            miscompares++;
        end
        SrcWL1 = '0;
        #1;
        vectors++;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL read_no_wordline: got %h want %h", SrcData1, 16'h0000);
            miscompares++;
        end
    endtask

    task automatic test_basic_write_read;
        do_write(16'h0008, 16'h1234);
        SrcWL1 = 16'h0008;
        SrcWL2 = 16'h0008;
        #1;
        vectors++;
        if (SrcData1 !== 16'h1234) begin
            $display("FAIL basic_port1: got %h want %h", SrcData1, 16'h1234);
            miscompares++;
        end
        vectors++;
        if (SrcData2 !== 16'h1234) begin
            $display("FAIL basic_port2: got %h want %h", SrcData2, 16'h1234);
            miscompares++;
        end
        SrcWL1 = '0;
        SrcWL2 = '0;
    endtask

    task automatic test_r0_protect;
        do_write(16'h0002, 16'h1111);
        do_write(16'h0004, 16'h2222);
        @(negedge clk);
        WriteReg = 1'b1;
        DstWL    = 16'h0001;
        DstData  = 16'hFFFF;
        SrcWL1   = 16'h0001;
        #1;
        vectors++;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL r0_no_bypass: got %h want %h", SrcData1, 16'h0000);
            miscompares++;
        end
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        DstWL    = '0;
        DstData  = '0;
        #1;
        vectors++;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL r0_after_write: got %h want %h", SrcData1, 16'h0000);
            miscompares++;
        end
        // Two distinct registers on the two ports at once.
        SrcWL1 = 16'h0002;
        SrcWL2 = 16'h0008;
        #1;
        vectors++;
        if (SrcData1 !== 16'h1111) begin
            $display("FAIL r0_r1_unchanged: got %h want %h", SrcData1, 16'h1111);
            miscompares++;
        end
        vectors++;
        if (SrcData2 !== 16'h1234) begin
            $display("FAIL r0_r3_unchanged: got %h want %h", SrcData2, 16'h1234);
            miscompares++;
        end
        SrcWL1 = '0;
        SrcWL2 = '0;
    endtask

    task automatic test_same_cycle;
        logic [15:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 16'hA5A5;
`else
        exp_now = 16'h0000;
`endif
        @(negedge clk);
        WriteReg = 1'b1;
        DstWL    = 16'h0080;
        DstData  = 16'hA5A5;
        SrcWL1   = 16'h0080;
        #1;
        vectors++;
        if (SrcData1 !== exp_now) begin
            $display("FAIL same_cycle_write_cycle: got %h want %h", SrcData1, exp_now);
            miscompares++;
        end
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        DstWL    = '0;
        DstData  = '0;
        #1;
        vectors++;
        if (SrcData1 !== 16'hA5A5) begin
            $display("FAIL same_cycle_next_cycle: got %h want %h", SrcData1, 16'hA5A5);
            miscompares++;
        end
        SrcWL1 = '0;
    endtask

    task automatic test_write_disabled;
        do_write(16'h0010, 16'h4444);
        @(negedge clk);
        WriteReg = 1'b0;
        DstWL    = 16'h0010;
        DstData  = 16'h9999;
        @(posedge clk);
        #1;
        // Malformed DstWL with WriteReg low must not raise the error.
        DstWL = 16'h0030;
        @(posedge clk);
        #1;
        DstWL   = '0;
        DstData = '0;
        SrcWL2  = 16'h0010;
        #1;
        vectors++;
        if (SrcData2 !== 16'h4444) begin
            $display("FAIL wr_disabled_r4: got %h want %h", SrcData2, 16'h4444);
            miscompares++;
        end
        vectors++;
        if (WLError !== 1'b0) begin
            $display("FAIL wr_disabled_wlerror: got %b want %b", WLError, 1'b0);
            miscompares++;
        end
        SrcWL2 = '0;
    endtask

    task automatic test_malformed_write;
        @(negedge clk);
        WriteReg = 1'b1;
        DstWL    = 16'h0006;
        DstData  = 16'h5555;
        SrcWL1   = 16'h0006;
        #1;
        vectors++;
        if (SrcData1 !== 16'h3333) begin
            $display("FAIL malformed_read_or: got %h want %h", SrcData1, 16'h3333);
            miscompares++;
        end
        vectors++;
        if (WLError !== 1'b0) begin
            $display("FAIL malformed_err_before_edge: got %b want %b", WLError, 1'b0);
            miscompares++;
        end
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        DstWL    = '0;
        DstData  = '0;
        SrcWL1   = 16'h0002;
        SrcWL2   = 16'h0004;
        #1;
        vectors++;
        if (SrcData1 !== 16'h1111) begin
            $display("FAIL malformed_r1_kept: got %h want %h", SrcData1, 16'h1111);
            miscompares++;
        end
        vectors++;
        if (SrcData2 !== 16'h2222) begin
            $display("FAIL malformed_r2_kept: got %h want %h", SrcData2, 16'h2222);
            miscompares++;
        end
        vectors++;
        if (WLError !== 1'b1) begin
            $display("FAIL malformed_err_set: got %b want %b", WLError, 1'b1);
            miscompares++;
        end
        SrcWL1 = '0;
        SrcWL2 = '0;
        repeat (3) idle_cycle();
        vectors++;
        if (WLError !== 1'b1) begin
            $display("FAIL malformed_err_sticky: got %b want %b", WLError, 1'b1);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (WLError !== 1'b0) begin
            $display("FAIL malformed_err_reset: got %b want %b", WLError, 1'b0);
            miscompares++;
        end
    endtask

    task automatic test_malformed_read;
        @(negedge clk);
        SrcWL2 = 16'h0003;
        @(posedge clk);
        #1;
        SrcWL2 = '0;
        vectors++;
        if (WLError !== 1'b1) begin
            $display("FAIL bad_read_wl_err: got %b want %b", WLError, 1'b1);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        SrcWL1      = '0;
        SrcWL2      = '0;
        DstWL       = '0;
        WriteReg    = 1'b0;
        DstData     = '0;
        test_reset();
        test_basic_write_read();
        test_r0_protect();
        test_same_cycle();
        test_write_disabled();
        test_malformed_write();
        test_malformed_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry x 16-bit general-purpose register file for the single-cycle/pipelined WISC CPU.
- Consumes the one-hot wordlines produced by the 4:16 read/write register-ID decoders in the decode stage.
- Holds architectural state.
- Provides two read ports (SrcReg1, SrcReg2) and one write port (DstReg) for writeback.

Parameters:
- DATA_WIDTH, 16, width of each register and of every data port.
- NUM_REGS, 16, number of registers; fixed at 16 (IDs are 4 bits, wordlines are 16 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- SrcWL1  input  16  one-hot read wordline, port 1; all-zero means no read.
- SrcWL2  input  16  one-hot read wordline, port 2.
- DstWL  input  16  one-hot write wordline from the write decoder.
- WriteReg  input  1  write enable; DstWL is ignored when low.
- DstData  input  16  writeback data.
- SrcData1  output  16  read data, port 1.
- SrcData2  output  16  read data, port 2.
- WLError  output  1  registered flag; set when any wordline input is not one-hot/zero.

Behaviour:
- Storage: 16 registers, R0..R15, one per wordline bit; wordline bit i selects Ri.
- Reset:
  - If rst_n=0 at a rising edge, all 16 registers clear to 16'h0000 and WLError clears to 0.
  - Writes in that cycle are discarded.
  - Reset applied mid-operation takes effect at the next edge, regardless of WriteReg.
- Write:
  - On a rising edge with rst_n=1, WriteReg=1 and DstWL one-hot with bit i set, Ri <= DstData.
  - Latency is 1 cycle: the value is architecturally visible from the next cycle.
  - WriteReg=0 or DstWL=0 means no register changes.
- R0 is hardwired zero:
  - Writes targeting DstWL[0] are dropped.
  - Reads of R0 always return 16'h0000.
- Read:
  - Combinational from stored state (zero cycles).
  - SrcDataN = Ri when SrcWLN has bit i set.
  - SrcWLN = 0 gives SrcDataN = 16'h0000.
- Both read ports may select the same register at the same time; both return the same value.
- Malformed wordline (more than one bit set on any of SrcWL1/SrcWL2/DstWL, DstWL checked only when WriteReg=1):
  - Reads return the bitwise OR of the selected registers.
  - The write is suppressed entirely.
  - WLError is set on the next edge and is sticky until reset.
- Width rule: no arithmetic; the data path is pass-through at DATA_WIDTH bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-before-read forwarding.
  - If WriteReg=1, DstWL is one-hot with bit i (i != 0) set, and SrcWLN has the same bit i set, then SrcDataN = DstData in that same cycle (combinational).
  - Never bypasses R0.
  - Never bypasses a suppressed (malformed) write.
- Undefined: reads return the stored value only; newly written data appears on the cycle after the write edge.

Test Plan:
- Reset: hold rst_n=0 for 2 edges after writing R5=16'hBEEF; release; read SrcWL1=16'h0020 -> SrcData1=16'h0000, WLError=0.
- Basic write/read: WriteReg=1, DstWL=16'h0008, DstData=16'h1234; next cycle SrcWL1=16'h0008, SrcWL2=16'h0008 -> both outputs 16'h1234.
- R0 protection: write 16'hFFFF with DstWL=16'h0001 -> reading R0 returns 16'h0000; all other registers unchanged.
- Same-cycle write/read of R7=16'hA5A5:
  - With REGFILE_BYPASS_EN: SrcData1=16'hA5A5 in the write cycle.
  - Without it: old value in the write cycle, 16'hA5A5 in the next cycle.
- Malformed write: WriteReg=1, DstWL=16'h0006, DstData=16'h5555 -> R1 and R2 keep prior values; WLError=1 after the edge and stays 1 until rst_n=0.
- Write disabled: WriteReg=0, DstWL=16'h0010, DstData=16'h9999 -> R4 unchanged; WLError stays 0.
